// File: rtl/b8b10_enc.sv
// b8b10_enc: two-stage pipelined 8b/10b encoder (5b/6b in S1, 3b/4b in S2) with valid/ready flow control.
// Define B8B10_ENC_KCHAR_EN to honour k_in and encode K28.x, K23.7, K27.7, K29.7 and K30.7.
module b8b10_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] encoded_val,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rd_out,
  output logic       k_err
);

  // RD- column of the 5b/6b table; the RD+ column is the complement where needed.
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:    code6 = 6'b100111;
      5'd1:    code6 = 6'b011101;
      5'd2:    code6 = 6'b101101;
      5'd3:    code6 = 6'b110001;
      5'd4:    code6 = 6'b110101;
      5'd5:    code6 = 6'b101001;
      5'd6:    code6 = 6'b011001;
      5'd7:    code6 = 6'b111000;
      5'd8:    code6 = 6'b111001;
      5'd9:    code6 = 6'b100101;
      5'd10:   code6 = 6'b010101;
      5'd11:   code6 = 6'b110100;
      5'd12:   code6 = 6'b001101;
      5'd13:   code6 = 6'b101100;
      5'd14:   code6 = 6'b011100;
      5'd15:   code6 = 6'b010111;
      5'd16:   code6 = 6'b011011;
      5'd17:   code6 = 6'b100011;
      5'd18:   code6 = 6'b010011;
      5'd19:   code6 = 6'b110010;
      5'd20:   code6 = 6'b001011;
      5'd21:   code6 = 6'b101010;
      5'd22:   code6 = 6'b011010;
      5'd23:   code6 = 6'b111010;
      5'd24:   code6 = 6'b110011;
      5'd25:   code6 = 6'b100110;
      5'd26:   code6 = 6'b010110;
      5'd27:   code6 = 6'b110110;
      5'd28:   code6 = 6'b001110;
      5'd29:   code6 = 6'b101110;
      5'd30:   code6 = 6'b011110;
      default: code6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] code4(input logic [2:0] y);
    case (y)
      3'd0:    code4 = 4'b1011;
      3'd1:    code4 = 4'b1001;
      3'd2:    code4 = 4'b0101;
      3'd3:    code4 = 4'b1100;
      3'd4:    code4 = 4'b1101;
      3'd5:    code4 = 4'b1010;
      3'd6:    code4 = 4'b0110;
      default: code4 = 4'b1110;
    endcase
  endfunction

  logic       s1_valid;
  logic [5:0] s1_code6;
  logic [4:0] s1_x;
  logic [2:0] s1_y;
  logic       s1_is_k;
  logic       s1_k_bad;
  logic       s1_rd_mid;

  logic       s2_load;
  logic       s1_adv;

  logic [4:0] x_in;
  logic [2:0] y_in;
  logic       k_req;
  logic       k28;
  logic       k_legal;
  logic       is_k;
  logic       k_bad;
  logic [5:0] c6_base;
  logic [5:0] c6;
  logic       alt6;
  logic       rd_in;
  logic       rd_mid;

  logic       a7;
  logic       k_swap;
  logic [3:0] c4_base;
  logic [3:0] c4;
  logic       alt4;
  logic       s2_rd_next;

  assign x_in = data_in[4:0];
  assign y_in = data_in[7:5];

`ifdef B8B10_ENC_KCHAR_EN
  assign k_req = k_in;
`else
  logic k_in_unused;
  assign k_in_unused = k_in;
  assign k_req       = 1'b0;
`endif

  assign s2_load  = enable && (!out_valid || out_ready);
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = rst && enable && (!s1_valid || s1_adv);

  // A symbol entering S1 behind an advancing S1 symbol must see that symbol's final RD.
  assign rd_in = s1_valid ? s2_rd_next : rd_out;

  always_comb begin
    k28     = (x_in == 5'd28);
    k_legal = k28 || ((y_in == 3'd7) &&
              (x_in == 5'd23 || x_in == 5'd27 || x_in == 5'd29 || x_in == 5'd30));
    is_k    = k_req && k_legal;
    k_bad   = k_req && !k_legal;
    c6_base = (is_k && k28) ? 6'b001111 : code6(x_in);
    alt6    = ($countones(c6_base) != 3) || (c6_base == 6'b111000);
    c6      = (rd_in && alt6) ? ~c6_base : c6_base;
    rd_mid  = rd_in ^ alt6;
  end

  // K28 neutral 4b codes use the complemented pattern but leave RD untouched.
  always_comb begin
    a7     = s1_is_k ||
             (s1_rd_mid ? (s1_x == 5'd11 || s1_x == 5'd13 || s1_x == 5'd14)
                        : (s1_x == 5'd17 || s1_x == 5'd18 || s1_x == 5'd20));
    k_swap = s1_is_k && (s1_y == 3'd1 || s1_y == 3'd2 || s1_y == 3'd5 || s1_y == 3'd6);
    if (s1_y == 3'd7)
      c4_base = a7 ? 4'b0111 : 4'b1110;
    else if (k_swap)
      c4_base = ~code4(s1_y);
    else
      c4_base = code4(s1_y);
    alt4       = k_swap || ($countones(c4_base) != 2) || (c4_base == 4'b1100);
    c4         = (s1_rd_mid && alt4) ? ~c4_base : c4_base;
    s2_rd_next = s1_rd_mid ^ (alt4 && !k_swap);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_code6  <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_is_k   <= 1'b0;
      s1_k_bad  <= 1'b0;
      s1_rd_mid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code6  <= c6;
        s1_x      <= x_in;
        s1_y      <= y_in;
        s1_is_k   <= is_k;
        s1_k_bad  <= k_bad;
        s1_rd_mid <= rd_mid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      encoded_val <= 10'h000;
      k_err       <= 1'b0;
      rd_out      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        encoded_val <= {s1_code6, c4};
        k_err       <= s1_k_bad;
        rd_out      <= s2_rd_next;
      end
    end
  end

endmodule

// File: tb/tb_b8b10_enc.sv
// tb_b8b10_enc: randomized self-checking bench for b8b10_enc against a table/disparity reference model.
// Honours B8B10_ENC_KCHAR_EN the same way the design does.
module tb_b8b10_enc;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data_in;
  logic       k_in;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] encoded_val;
  logic       out_valid;
  logic       out_ready;
  logic       rd_out;
  logic       k_err;

`ifdef B8B10_ENC_KCHAR_EN
  localparam bit KCHAR = 1'b1;
`else
  localparam bit KCHAR = 1'b0;
`endif

  int          n_checks = 0;
  int          n_bad    = 0;
  int          n_out    = 0;
  int          idx;
  int          out_base;
  logic [11:0] exp_q[$];
  logic        model_rd;
  logic        last_acc;

  logic [5:0] t6 [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4 [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] k4 [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [7:0] k_list [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] stall_bytes [0:3] = '{8'h3A, 8'h07, 8'hF1, 8'h63};

  b8b10_enc dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .data_in     (data_in),
    .k_in        (k_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .encoded_val (encoded_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd_out      (rd_out),
    .k_err       (k_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Reference: pick the sub-block variant that pulls RD back toward zero, then recount disparity.
  task automatic modelEncode(input logic [7:0] d, input logic k, output logic [11:0] res);
    logic [4:0] x;
    logic [2:0] y;
    logic       kreq, kok, kerr, a7;
    logic [5:0] s6;
    logic [3:0] s4;
    int         n;
    x = d[4:0];
    y = d[7:5];
    kreq = KCHAR && k;
    kok = 1'b0;
    foreach (k_list[i]) if (k_list[i] == d) kok = 1'b1;
    kerr = kreq && !kok;
    s6 = (kreq && kok && x == 5'd28) ? 6'b001111 : t6[x];
    n = $countones(s6);
    if (n != 3) begin
      if ((n > 3) == model_rd) s6 = ~s6;
      model_rd = ($countones(s6) > 3);
    end else if (s6 == 6'b111000) begin
      s6 = model_rd ? 6'b000111 : 6'b111000;
      model_rd = !model_rd;
    end
    if (kreq && kok) begin
      s4 = model_rd ? ~k4[y] : k4[y];
      if ($countones(s4) != 2 || s4 == 4'b1100 || s4 == 4'b0011) model_rd = !model_rd;
    end else if (y == 3'd7) begin
      a7 = model_rd ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                    : (x == 5'd17 || x == 5'd18 || x == 5'd20);
      s4 = a7 ? 4'b0111 : 4'b1110;
      if (model_rd) s4 = ~s4;
      model_rd = !model_rd;
    end else begin
      s4 = t4[y];
      n = $countones(s4);
      if (n != 2) begin
        if ((n > 2) == model_rd) s4 = ~s4;
        model_rd = ($countones(s4) > 2);
      end else if (s4 == 4'b1100) begin
        s4 = model_rd ? 4'b0011 : 4'b1100;
        model_rd = !model_rd;
      end
    end
    res = {kerr, model_rd, s6, s4};
  endtask

  // Drives one cycle from a falling edge and scores the transfers the next rising edge will make.
  task automatic applyStimulus(input logic [7:0] d, input logic k, input logic v,
                               input logic ordy, input logic en);
    logic [11:0] e;
    data_in   = d;
    k_in      = k;
    in_valid  = v;
    out_ready = ordy;
    enable    = en;
    #1;
    last_acc = 1'b0;
    if (!rst) begin
      checkOutput("rst_ready", 32'(in_ready), 0);
      exp_q.delete();
      model_rd = 1'b0;
    end else begin
      if (!enable) checkOutput("en0_ready", 32'(in_ready), 0);
      if (enable && out_valid && out_ready) begin
        checkOutput("out_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_out++;
          checkOutput("code", 32'(encoded_val), 32'(e[9:0]));
          checkOutput("rd", 32'(rd_out), 32'(e[10]));
          checkOutput("kerr", 32'(k_err), 32'(e[11]));
        end
      end
      if (in_valid && in_ready) begin
        modelEncode(d, k, e);
        exp_q.push_back(e);
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic expectNow(input string tag, input logic [9:0] code, input logic rd, input logic ke);
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_code"}, 32'(encoded_val), 32'(code));
    checkOutput({tag, "_rd"}, 32'(rd_out), 32'(rd));
    checkOutput({tag, "_kerr"}, 32'(k_err), 32'(ke));
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++)
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput(tag, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; data_in = '0; k_in = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; model_rd = 1'b0; last_acc = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_code", 32'(encoded_val), 0);
    checkOutput("rst_rd", 32'(rd_out), 0);
    checkOutput("rst_kerr", 32'(k_err), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 checkOutput("ready_after_rst", 32'(in_ready), 1);
    @(negedge clk);

    // D0.0 from reset: nothing after one cycle, code after two
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("lat_1cyc", 32'(out_valid), 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("d0_0", 10'h274, 1'b0, 1'b0);
    drain("d0_0_drain");

    doReset();
    applyStimulus(8'hB5, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'hF1, 1'b0, 1'b1, 1'b1, 1'b1);
    expectNow("d21_5", 10'h2AA, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("d17_7", 10'h237, 1'b1, 1'b0);
    drain("d17_7_drain");

    doReset();
    applyStimulus(8'hBC, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'hBC, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef B8B10_ENC_KCHAR_EN
    expectNow("k28_5a", 10'h0FA, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("k28_5b", 10'h305, 1'b0, 1'b0);
`else
    expectNow("d28_5a", 10'h0EA, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("d28_5b", 10'h0EA, 1'b0, 1'b0);
`endif
    drain("k28_drain");

    doReset();
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("k_illegal", 10'h274, 1'b0, KCHAR);
    drain("k_illegal_drain");

    // Four bytes with the sink stalled for three cycles mid-stream
    doReset();
    idx = 0;
    out_base = n_out;
    for (int c = 0; c < 30; c++) begin
      if (c == 3 || c == 4) begin
        checkOutput("stall_ready", 32'(in_ready), 0);
        checkOutput("stall_hold", 32'(encoded_val),
                    32'(exp_q.size() > 0 ? exp_q[0][9:0] : 10'h3FF));
      end
      applyStimulus(idx < 4 ? stall_bytes[idx] : 8'h00, 1'b0, idx < 4, !(c >= 2 && c <= 4), 1'b1);
      if (last_acc) idx++;
      if (idx == 4 && exp_q.size() == 0) break;
    end
    checkOutput("stall_all_in", idx, 4);
    checkOutput("stall_all_out", n_out - out_base, 4);
    checkOutput("stall_drain", exp_q.size(), 0);

    doReset();
    for (int c = 0; c < 600; c++) begin
      logic [7:0] d;
      logic       k;
      d = 8'($urandom);
      if ($urandom_range(3) == 0) d = k_list[$urandom_range(11)];
      k = ($urandom_range(2) == 0);
      applyStimulus(d, k, $urandom_range(4) != 0, $urandom_range(3) != 0, $urandom_range(7) != 0);
    end
    drain("rand_drain");

    // Reset with both stages occupied
    doReset();
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b1, 1'b1);
    drain("d0_1_drain");
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_rst_rd", 32'(rd_out), 1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h05, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pre_rst_full", 32'(out_valid), 1);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_rd", 32'(rd_out), 0);
    checkOutput("mid_rst_code", 32'(encoded_val), 0);
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    expectNow("post_rst_d0", 10'h274, 1'b0, 1'b0);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
